// File: rtl/jk_ff_monitor.sv
// jk_ff_monitor: registered checker for an SR-based JK flip-flop.
// Tracks a JK reference model and compares it with the flop's q_/q_bar.
// Flags mismatches and complement faults, and counts output edges.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   JK            command also driven to the flop ({J,K})
//   q_, q_bar     flop outputs under test
//   clr_err       synchronous clear of fault state and counters
//   exp_q         reference-model Q
//   chk_en        high while checking (CHECK state)
//   mismatch      one-cycle pulse, q_ differed from exp_q
//   comp_err      one-cycle pulse, q_ equal to q_bar
//   err_sticky    high while latched in FAULT
//   rise, fall    one-cycle pulses on q_ edges
//   toggle_cnt    saturating q_ edge count
//   mismatch_cnt  saturating failing-edge count
module jk_ff_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       JK,
    input  logic             q_,
    input  logic             q_bar,
    input  logic             clr_err,
    output logic             exp_q,
    output logic             chk_en,
    output logic             mismatch,
    output logic             comp_err,
    output logic             err_sticky,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [CNT_W-1:0] mismatch_cnt
);

    typedef enum logic [1:0] {
        S_RESET,
        S_ARM,
        S_CHECK,
        S_FAULT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic             r_exp_q;
    logic             r_q_prev;
    logic             r_mismatch;
    logic             r_comp_err;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_toggle_cnt;
    logic [CNT_W-1:0] r_mismatch_cnt;

    logic w_in_check;
    logic w_watch;
    logic w_mis;
    logic w_comp;
    logic w_fail;
    logic w_edge;
    logic w_tog_max;
    logic w_mis_max;

    assign w_in_check = (r_state == S_CHECK);
    assign w_watch    = (r_state == S_CHECK) || (r_state == S_FAULT);

    // q_ carries the flop value set on the previous edge, and so does
    // r_exp_q, so both are compared before the model advances.
    assign w_mis     = (q_ != r_exp_q);
    assign w_comp    = (q_ == q_bar);
    assign w_fail    = w_mis || w_comp;
    assign w_edge    = q_ ^ r_q_prev;
    assign w_tog_max = &r_toggle_cnt;
    assign w_mis_max = &r_mismatch_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_RESET: w_next = S_ARM;
            S_ARM:   w_next = S_CHECK;
            S_CHECK: begin
                if (w_fail) begin
                    w_next = S_FAULT;
                end
            end
            S_FAULT: w_next = S_FAULT;
        endcase
        // Clear has priority over any fault seen on the same edge.
        if (clr_err) begin
            w_next = S_ARM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exp_q        <= 1'b0;
            r_q_prev       <= 1'b0;
            r_mismatch     <= 1'b0;
            r_comp_err     <= 1'b0;
            r_rise         <= 1'b0;
            r_fall         <= 1'b0;
            r_toggle_cnt   <= '0;
            r_mismatch_cnt <= '0;
        end else begin
            unique case (JK)
                2'b00: r_exp_q <= r_exp_q;
                2'b01: r_exp_q <= 1'b0;
                2'b10: r_exp_q <= 1'b1;
                2'b11: r_exp_q <= ~r_exp_q;
            endcase

            if (r_state != S_RESET) begin
                r_q_prev <= q_;
            end

            if (clr_err) begin
                r_mismatch     <= 1'b0;
                r_comp_err     <= 1'b0;
                r_rise         <= 1'b0;
                r_fall         <= 1'b0;
                r_toggle_cnt   <= '0;
                r_mismatch_cnt <= '0;
            end else begin
                // New pulses only in CHECK; FAULT still counts failures.
                r_mismatch <= w_in_check && w_mis;
                r_comp_err <= w_in_check && w_comp;
                r_rise     <= w_watch && q_ && !r_q_prev;
                r_fall     <= w_watch && !q_ && r_q_prev;

                if (w_watch && w_fail && !w_mis_max) begin
                    r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(1);
                end
                if (w_watch && w_edge && !w_tog_max) begin
                    r_toggle_cnt <= r_toggle_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign exp_q        = r_exp_q;
    assign chk_en       = (r_state == S_CHECK);
    assign err_sticky   = (r_state == S_FAULT);
    assign mismatch     = r_mismatch;
    assign comp_err     = r_comp_err;
    assign rise         = r_rise;
    assign fall         = r_fall;
    assign toggle_cnt   = r_toggle_cnt;
    assign mismatch_cnt = r_mismatch_cnt;

endmodule

// File: tb/tb_jk_ff_monitor.sv
// tb_jk_ff_monitor: directed bench for jk_ff_monitor.
// A local JK flop drives q_/q_bar; an override injects faults.
module tb_jk_ff_monitor;

    logic       clk;
    logic       rst;
    logic [1:0] JK;
    logic       clr_err;
    logic       q_;
    logic       q_bar;
    logic       exp_q;
    logic       chk_en;
    logic       mismatch;
    logic       comp_err;
    logic       err_sticky;
    logic       rise;
    logic       fall;
    logic [7:0] toggle_cnt;
    logic [7:0] mismatch_cnt;

    logic flop_q;
    logic ovr;
    logic ovr_q;
    logic ovr_qb;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [1:0] jk;
        logic       eq;
        logic [7:0] tog;
        logic       ri;
        logic       fa;
    } vec_t;

    vec_t tbl [10];

    jk_ff_monitor #(.CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .JK           (JK),
        .q_           (q_),
        .q_bar        (q_bar),
        .clr_err      (clr_err),
        .exp_q        (exp_q),
        .chk_en       (chk_en),
        .mismatch     (mismatch),
        .comp_err     (comp_err),
        .err_sticky   (err_sticky),
        .rise         (rise),
        .fall         (fall),
        .toggle_cnt   (toggle_cnt),
        .mismatch_cnt (mismatch_cnt)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flop_q <= 1'b0;
        end else begin
            unique case (JK)
                2'b00: flop_q <= flop_q;
                2'b01: flop_q <= 1'b0;
                2'b10: flop_q <= 1'b1;
                2'b11: flop_q <= ~flop_q;
            endcase
        end
    end

    assign q_    = ovr ? ovr_q  : flop_q;
    assign q_bar = ovr ? ovr_qb : ~flop_q;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".exp_q"},        32'(exp_q),        0);
        chk({tag, ".chk_en"},       32'(chk_en),       0);
        chk({tag, ".mismatch"},     32'(mismatch),     0);
        chk({tag, ".comp_err"},     32'(comp_err),     0);
        chk({tag, ".err_sticky"},   32'(err_sticky),   0);
        chk({tag, ".rise"},         32'(rise),         0);
        chk({tag, ".fall"},         32'(fall),         0);
        chk({tag, ".toggle_cnt"},   32'(toggle_cnt),   0);
        chk({tag, ".mismatch_cnt"}, 32'(mismatch_cnt), 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // JK 10,01,11,00,10 each for two edges on a correct flop.
        tbl[0] = '{2'b10, 1'b1, 8'd0, 1'b0, 1'b0};
        tbl[1] = '{2'b10, 1'b1, 8'd1, 1'b1, 1'b0};
        tbl[2] = '{2'b01, 1'b0, 8'd1, 1'b0, 1'b0};
        tbl[3] = '{2'b01, 1'b0, 8'd2, 1'b0, 1'b1};
        tbl[4] = '{2'b11, 1'b1, 8'd2, 1'b0, 1'b0};
        tbl[5] = '{2'b11, 1'b0, 8'd3, 1'b1, 1'b0};
        tbl[6] = '{2'b00, 1'b0, 8'd4, 1'b0, 1'b1};
        tbl[7] = '{2'b00, 1'b0, 8'd4, 1'b0, 1'b0};
        tbl[8] = '{2'b10, 1'b1, 8'd4, 1'b0, 1'b0};
        tbl[9] = '{2'b10, 1'b1, 8'd5, 1'b1, 1'b0};

        // Reset with an arbitrary q_ on the inputs.
        rst     = 1'b1;
        JK      = 2'b00;
        clr_err = 1'b0;
        ovr     = 1'b1;
        ovr_q   = 1'b1;
        ovr_qb  = 1'b1;
        #10;
        chk_all_zero("reset");
        rst = 1'b0;
        ovr = 1'b0;
        tick();
        chk("arm.chk_en", 32'(chk_en), 0);
        tick();
        chk("check.chk_en", 32'(chk_en), 1);

        // Correct flop.
        for (int i = 0; i < 10; i++) begin
            JK = tbl[i].jk;
            tick();
            chk($sformatf("vec%0d.exp_q", i), 32'(exp_q), 32'(tbl[i].eq));
            chk($sformatf("vec%0d.toggle_cnt", i), 32'(toggle_cnt),
                32'(tbl[i].tog));
            chk($sformatf("vec%0d.rise", i), 32'(rise), 32'(tbl[i].ri));
            chk($sformatf("vec%0d.fall", i), 32'(fall), 32'(tbl[i].fa));
            chk($sformatf("vec%0d.mismatch_cnt", i), 32'(mismatch_cnt), 0);
            chk($sformatf("vec%0d.err_sticky", i), 32'(err_sticky), 0);
        end

        // Single-error injection with exp_q=1.
        JK     = 2'b00;
        ovr    = 1'b1;
        ovr_q  = 1'b0;
        ovr_qb = 1'b1;
        tick();
        ovr = 1'b0;
        chk("inj.mismatch", 32'(mismatch), 1);
        chk("inj.comp_err", 32'(comp_err), 0);
        chk("inj.mismatch_cnt", 32'(mismatch_cnt), 1);
        chk("inj.err_sticky", 32'(err_sticky), 1);
        chk("inj.chk_en", 32'(chk_en), 0);
        tick();
        chk("inj.pulse_end", 32'(mismatch), 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("hold%0d.err_sticky", i), 32'(err_sticky), 1);
            chk($sformatf("hold%0d.mismatch", i), 32'(mismatch), 0);
            chk($sformatf("hold%0d.mismatch_cnt", i), 32'(mismatch_cnt), 1);
        end

        // Plain clear back to CHECK.
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr1.err_sticky", 32'(err_sticky), 0);
        chk("clr1.chk_en", 32'(chk_en), 0);
        chk("clr1.mismatch_cnt", 32'(mismatch_cnt), 0);
        chk("clr1.toggle_cnt", 32'(toggle_cnt), 0);
        tick();
        chk("clr1.rearm", 32'(chk_en), 1);

        // Complement violation with q_ == exp_q == 1.
        ovr    = 1'b1;
        ovr_q  = 1'b1;
        ovr_qb = 1'b1;
        tick();
        ovr = 1'b0;
        chk("comp.comp_err", 32'(comp_err), 1);
        chk("comp.mismatch", 32'(mismatch), 0);
        chk("comp.mismatch_cnt", 32'(mismatch_cnt), 1);
        chk("comp.err_sticky", 32'(err_sticky), 1);
        tick();
        chk("comp.pulse_end", 32'(comp_err), 0);

        // Two more failing edges while in FAULT.
        ovr    = 1'b1;
        ovr_q  = 1'b0;
        ovr_qb = 1'b1;
        tick();
        tick();
        chk("fault.mismatch_cnt", 32'(mismatch_cnt), 3);
        chk("fault.no_pulse", 32'(mismatch), 0);

        // Clear on an edge that also mismatches.
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        ovr     = 1'b0;
        chk("clrp.mismatch_cnt", 32'(mismatch_cnt), 0);
        chk("clrp.toggle_cnt", 32'(toggle_cnt), 0);
        chk("clrp.err_sticky", 32'(err_sticky), 0);
        chk("clrp.mismatch", 32'(mismatch), 0);
        chk("clrp.chk_en", 32'(chk_en), 0);
        chk("clrp.exp_q", 32'(exp_q), 1);
        tick();
        chk("clrp.rearm", 32'(chk_en), 1);
        chk("clrp.exp_q2", 32'(exp_q), 1);

        // Simultaneous mismatch and complement fault.
        ovr    = 1'b1;
        ovr_q  = 1'b0;
        ovr_qb = 1'b0;
        tick();
        ovr = 1'b0;
        chk("both.mismatch", 32'(mismatch), 1);
        chk("both.comp_err", 32'(comp_err), 1);
        chk("both.mismatch_cnt", 32'(mismatch_cnt), 1);

        // Saturation: clear, re-arm, then toggle for 300 edges.
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tick();
        chk("sat.chk_en", 32'(chk_en), 1);
        JK = 2'b11;
        for (int i = 0; i < 300; i++) begin
            tick();
            chk($sformatf("sat%0d.exp_q", i), 32'(exp_q), 32'(i % 2));
            chk($sformatf("sat%0d.toggle_cnt", i), 32'(toggle_cnt),
                32'((i > 255) ? 255 : i));
            if (i >= 1) begin
                chk($sformatf("sat%0d.rise", i), 32'(rise),
                    32'(i % 2 == 0));
                chk($sformatf("sat%0d.fall", i), 32'(fall),
                    32'(i % 2 == 1));
            end
        end
        chk("sat.mismatch_cnt", 32'(mismatch_cnt), 0);
        chk("sat.err_sticky", 32'(err_sticky), 0);

        // Asynchronous reset mid-cycle, no clock edge needed.
        #5;
        rst = 1'b1;
        #1;
        chk_all_zero("areset");
        JK = 2'b00;
        @(negedge clk);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jk_ff_monitor.md
# jk_ff_monitor

Registered checker stage downstream of the SR-based JK flip-flop. Takes the same `JK` command the flop receives plus the flop's `q_`/`q_bar` outputs. Runs a cycle-accurate JK reference model and reports mismatches, complement violations, output edges and saturating event counts. Usable in simulation benches and as on-chip self-check logic.

## Interface
- `CNT_W`, default 8: width of `toggle_cnt` and `mismatch_cnt`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `JK`  in  2  command also driven to the flop: `JK[1]`=J, `JK[0]`=K.
- `q_`  in  1  flop true output.
- `q_bar`  in  1  flop complement output.
- `clr_err`  in  1  synchronous clear of fault state and counters.
- `exp_q`  out  1  reference-model Q.
- `chk_en`  out  1  high while in CHECK state.
- `mismatch`  out  1  one-cycle pulse: sampled `q_` differed from `exp_q`.
- `comp_err`  out  1  one-cycle pulse: `q_ == q_bar` while checking.
- `err_sticky`  out  1  high while in FAULT state.
- `rise`, `fall`  out  1 each  one-cycle pulses on `q_` 0→1 / 1→0.
- `toggle_cnt`  out  CNT_W  saturating count of `q_` edges.
- `mismatch_cnt`  out  CNT_W  saturating count of mismatch or comp_err events.

## Operation
- Reference model, updated every rising edge in every non-reset state:
  - `JK`=00: hold.
  - `JK`=01: `exp_q` ← 0.
  - `JK`=10: `exp_q` ← 1.
  - `JK`=11: `exp_q` ← ~`exp_q`.
- This matches the flop's reset value: Q=0 under reset.
- FSM states: RESET, ARM, CHECK, FAULT.
  - RESET: entered asynchronously while `rst`=1. Goes to ARM on the first edge after release.
  - ARM: goes to CHECK on the next edge. Covers one cycle of flop settling.
  - CHECK: goes to FAULT on any edge where `q_ != exp_q` or `q_ == q_bar`.
  - FAULT: holds until `rst` or `clr_err`.
- Compare rule: at edge n, `q_` (the flop value set at edge n−1) is compared with the current `exp_q` (also set at edge n−1). The model then advances.
- Pulse rules:
  - `mismatch` and `comp_err` are registered at edge n and are visible for exactly the following cycle.
  - Both pulses are generated only in CHECK. FAULT suppresses new pulses.
  - FAULT still increments `mismatch_cnt` for each failing edge.
- Edge detect uses a registered `q_prev`, loaded every edge from ARM onward.
  - `rise` = `q_ & ~q_prev`; `fall` = `~q_ & q_prev`.
  - Both are evaluated only when in CHECK or FAULT.
  - Each `rise`/`fall` increments `toggle_cnt`.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `clr_err`:
  - Zeroes both counters and all pulse outputs, and goes to ARM.
  - `exp_q` is not cleared; the model keeps tracking.
  - `clr_err` wins over a simultaneous mismatch, comp_err or edge event on that same edge.

## Timing
- Reset values, asynchronous while `rst`=1: `exp_q`, `chk_en`, `mismatch`, `comp_err`, `err_sticky`, `rise`, `fall` are all 0. Both counters are 0. `q_prev` is 0.
- Reset mid-operation: all outputs return to reset values immediately, with no clock required. Re-arming takes 2 edges after release.
- Latency: a flop error produced at edge n−1 shows as `mismatch` high in the cycle after edge n. `err_sticky` rises in the same cycle.
- `chk_en` is high from the edge that enters CHECK and low in FAULT.
- All outputs are registered; there are no combinational input-to-output paths.
- Simultaneous mismatch and comp_err on one edge: both pulses assert and `mismatch_cnt` increments by 1, not 2.

## Test plan
- Reset test:
  - Stimulus: `rst`=1 for 10 ns with `JK`=00, arbitrary `q_`.
  - Required: every output 0. `chk_en`=1 at the second edge after release.
- Correct-flop test:
  - Stimulus: connect the real JK flop; clock period 50; apply `JK` 10, 01, 11, 00, 10, each for 2 cycles.
  - Required: `mismatch_cnt`=0, `err_sticky`=0. `exp_q` sequence per edge is 1,1,0,0,1,0,0,0,1,1. `toggle_cnt`=5.
- Single-error injection:
  - Stimulus: in CHECK with `exp_q`=1, force `q_`=0, `q_bar`=1 for one cycle.
  - Required: `mismatch` high for exactly one cycle, `mismatch_cnt`=1. `err_sticky`=1 and stays 1 for 20 further cycles.
- Complement violation:
  - Stimulus: in CHECK, drive `q_`=`q_bar`=1 with `exp_q`=1.
  - Required: `comp_err` pulses once, `mismatch`=0, `mismatch_cnt`=1, FAULT.
- Saturation:
  - Stimulus: `CNT_W`=8, `JK`=11 for 300 cycles with a correct flop.
  - Required: `toggle_cnt` reaches 255 and holds. `rise`/`fall` continue to alternate.
- Clear priority:
  - Stimulus: in FAULT with `mismatch_cnt`=3, assert `clr_err` on an edge that also has `q_ != exp_q`.
  - Required: counters 0, `err_sticky`=0, state ARM, then CHECK on the next edge. `exp_q` is unchanged by the clear.
